// File: rtl/hdlc_rx_deframer.sv
`timescale 1ns/1ps
// HDLC receive deframer: flag hunt, zero-bit removal, abort detection,
// optional CRC-16-CCITT check and a single-frame hold buffer for readout.
module hdlc_rx_deframer #(
    parameter int BUF_DEPTH = 128,
    parameter bit FCS_EN    = 1'b1,
    parameter int SZ_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            RxEN,
    input  logic            Rx,
    input  logic            RdBuff,
    input  logic            Drop,
    output logic [7:0]      DataOut,
    output logic            Ready,
    output logic [SZ_W-1:0] FrameSize,
    output logic            Overflow,
    output logic            AbortSignal,
    output logic            FrameError,
    output logic            FCSerr
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [SZ_W-1:0] DEPTH_V = SZ_W'(BUF_DEPTH);
    localparam logic [SZ_W-1:0] FCS_V   = SZ_W'(FCS_EN ? 2 : 0);
    localparam logic [SZ_W-1:0] MIN_V   = SZ_W'(FCS_EN ? 3 : 1);
    localparam logic [SZ_W-1:0] ONE_V   = SZ_W'(1);

    typedef enum logic [1:0] {HUNT, RECV, HOLD} state_t;

    state_t          state;
    logic [7:0]      window;
    logic [2:0]      inOnes;
    logic [2:0]      outOnes;
    logic [2:0]      skipCnt;
    logic [2:0]      bitCnt;
    logic [SZ_W-1:0] byteCnt;
    logic [SZ_W-1:0] rdPtr;
    logic [6:0]      byteReg;
    logic [15:0]     crc;
    logic            ovf;
    logic [7:0]      frameBuf [BUF_DEPTH];

    logic        outBit;
    logic        isFlag;
    logic        isAbort;
    logic        stuffed;
    logic        keepBit;
    logic        wrEn;
    logic        crcFb;
    logic [7:0]  nextByte;
    logic [15:0] crcNext;

    assign outBit   = window[0];
    assign isFlag   = (window == 8'h7E);
    assign isAbort  = (inOnes == 3'd7);
    assign stuffed  = (outOnes == 3'd5) && !outBit;
    assign nextByte = {outBit, byteReg};
    assign crcFb    = crc[0] ^ outBit;
    assign crcNext  = {1'b0, crc[15:1]} ^ (crcFb ? 16'h8408 : 16'h0000);
    assign keepBit  = RxEN && (state == RECV) && !isAbort && !isFlag
                    && (skipCnt == 3'd0) && !stuffed;
    assign wrEn     = keepBit && (bitCnt == 3'd7) && (byteCnt != DEPTH_V);

    always_ff @(posedge Clk) begin
        if (wrEn) frameBuf[byteCnt[PTR_W-1:0]] <= nextByte;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= HUNT;
            window      <= 8'h00;
            inOnes      <= 3'd0;
            outOnes     <= 3'd0;
            skipCnt     <= 3'd0;
            bitCnt      <= 3'd0;
            byteCnt     <= '0;
            rdPtr       <= '0;
            byteReg     <= 7'd0;
            crc         <= 16'hFFFF;
            ovf         <= 1'b0;
            DataOut     <= 8'h00;
            Ready       <= 1'b0;
            FrameSize   <= '0;
            Overflow    <= 1'b0;
            AbortSignal <= 1'b0;
            FrameError  <= 1'b0;
            FCSerr      <= 1'b0;
        end else begin
            AbortSignal <= 1'b0;
            FrameError  <= 1'b0;
            FCSerr      <= 1'b0;
            if (RxEN) begin
                window <= {Rx, window[7:1]};
                if (!Rx) inOnes <= 3'd0;
                else if (inOnes != 3'd7) inOnes <= inOnes + 3'd1;
            end
            unique case (state)
                HUNT: begin
                    if (RxEN && isFlag) begin
                        state   <= RECV;
                        bitCnt  <= 3'd0;
                        byteCnt <= '0;
                        crc     <= 16'hFFFF;
                        ovf     <= 1'b0;
                        skipCnt <= 3'd7;
                        outOnes <= 3'd0;
                    end
                end
                RECV: begin
                    if (!RxEN) begin
                        state <= RECV;
                    end else if (isAbort) begin
                        AbortSignal <= 1'b1;
                        state       <= HUNT;
                    end else if (isFlag) begin
                        // The closing flag also opens the next frame,
                        // so its remaining 7 bits must not reach the data path.
                        bitCnt  <= 3'd0;
                        byteCnt <= '0;
                        crc     <= 16'hFFFF;
                        ovf     <= 1'b0;
                        skipCnt <= 3'd7;
                        outOnes <= 3'd0;
                        rdPtr   <= '0;
                        if (byteCnt == '0 && bitCnt == 3'd0) begin
                            state <= RECV;
                        end else if (bitCnt != 3'd0 || byteCnt < MIN_V) begin
                            FrameError <= 1'b1;
                        end else if (ovf) begin
                            state     <= HOLD;
                            Ready     <= 1'b1;
                            Overflow  <= 1'b1;
                            FrameSize <= DEPTH_V - FCS_V;
                        end else if (FCS_EN && crc != 16'hF0B8) begin
                            FCSerr <= 1'b1;
                        end else begin
                            state     <= HOLD;
                            Ready     <= 1'b1;
                            Overflow  <= 1'b0;
                            FrameSize <= byteCnt - FCS_V;
                        end
                    end else if (skipCnt != 3'd0) begin
                        skipCnt <= skipCnt - 3'd1;
                    end else if (stuffed) begin
                        outOnes <= 3'd0;
                    end else begin
                        if (!outBit) outOnes <= 3'd0;
                        else if (outOnes != 3'd7) outOnes <= outOnes + 3'd1;
                        byteReg <= nextByte[7:1];
                        crc     <= crcNext;
                        bitCnt  <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            if (byteCnt == DEPTH_V) ovf <= 1'b1;
                            else byteCnt <= byteCnt + ONE_V;
                        end
                    end
                end
                HOLD: begin
                    if (Drop) begin
                        Ready <= 1'b0;
                        state <= HUNT;
                    end else if (RdBuff) begin
                        DataOut <= frameBuf[rdPtr[PTR_W-1:0]];
                        rdPtr   <= rdPtr + ONE_V;
                        if (rdPtr == FrameSize - ONE_V) begin
                            Ready <= 1'b0;
                            state <= HUNT;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
`timescale 1ns/1ps
// Scoreboard bench for hdlc_rx_deframer: directed frames on the serial line,
// expected events queued at stimulus time and checked by an output monitor.
module tb_hdlc_rx_deframer;
    localparam int DEPTH = 4;
    localparam int SZW = $clog2(DEPTH + 1);
    localparam int KREADY = 0;
    localparam int KDATA = 1;
    localparam int KABORT = 2;
    localparam int KFERR = 3;
    localparam int KFCS = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic RxEN = 1'b0;
    logic Rx = 1'b0;
    logic RdBuff = 1'b0;
    logic Drop = 1'b0;
    logic [7:0] DataOut;
    logic Ready;
    logic [SZW-1:0] FrameSize;
    logic Overflow;
    logic AbortSignal;
    logic FrameError;
    logic FCSerr;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t expQ[$];
    logic [7:0] payload[$];
    logic [15:0] fcs;
    int nCmp = 0;
    int nBad = 0;
    int cyc = 0;
    int readyCyc = -1;
    int closeCyc = 0;
    int stuffOnes = 0;
    bit readChk = 1'b0;
    bit rdEdge = 1'b0;
    bit prevReady = 1'b0;

    always #5 Clk = ~Clk;

    hdlc_rx_deframer #(.BUF_DEPTH(DEPTH), .FCS_EN(1'b1)) dut (
        .Clk(Clk), .Rst(Rst), .RxEN(RxEN), .Rx(Rx),
        .RdBuff(RdBuff), .Drop(Drop), .DataOut(DataOut),
        .Ready(Ready), .FrameSize(FrameSize), .Overflow(Overflow),
        .AbortSignal(AbortSignal), .FrameError(FrameError),
        .FCSerr(FCSerr)
    );

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        rdEdge <= RdBuff && readChk;
    end

    function automatic string kname(int k);
        case (k)
            KREADY: return "ready";
            KDATA: return "data";
            KABORT: return "abort";
            KFERR: return "frame_error";
            default: return "fcs_error";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic scoreEvent(int kind, int a, int b);
        ev_t e;
        nCmp++;
        if (expQ.size() == 0) begin
            nBad++;
            $display("FAIL unexpected %s: got %0h/%0h required none",
                     kname(kind), a, b);
            return;
        end
        e = expQ.pop_front();
        if (e.kind != kind || e.a != a || e.b != b) begin
            nBad++;
            $display("FAIL %s: got %s %0h/%0h required %s %0h/%0h",
                     kname(e.kind), kname(kind), a, b, kname(e.kind), e.a, e.b);
        end
    endtask

    always @(negedge Clk) begin
        if (Ready && !prevReady) begin
            readyCyc = cyc;
            scoreEvent(KREADY, int'(FrameSize), int'(Overflow));
        end
        if (rdEdge) scoreEvent(KDATA, int'(DataOut), 0);
        if (AbortSignal) scoreEvent(KABORT, 0, 0);
        if (FrameError) scoreEvent(KFERR, 0, 0);
        if (FCSerr) scoreEvent(KFCS, 0, 0);
        prevReady = Ready;
    end

    function automatic logic [15:0] crcOfPayload();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (payload[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ payload[i][b]) c = (c >> 1) ^ 16'h8408;
                else c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic sendBit(input logic b);
        @(negedge Clk);
        Rx = b;
        RxEN = 1'b1;
    endtask

    task automatic pause();
        @(negedge Clk);
        RxEN = 1'b0;
    endtask

    task automatic sendRaw(input logic [7:0] v);
        for (int i = 0; i < 8; i++) sendBit(v[i]);
    endtask

    task automatic sendFlag();
        sendRaw(8'h7E);
        stuffOnes = 0;
    endtask

    task automatic sendStuffed(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            sendBit(v[i]);
            if (v[i]) begin
                stuffOnes++;
                if (stuffOnes == 5) begin
                    sendBit(1'b0);
                    stuffOnes = 0;
                end
            end else begin
                stuffOnes = 0;
            end
        end
    endtask

    task automatic sendClose();
        sendRaw(8'h7E);
        closeCyc = cyc + 1;
        sendRaw(8'h7E);
        pause();
    endtask

    task automatic sendFrame(input bit badFcs);
        fcs = ~crcOfPayload();
        if (badFcs) fcs = fcs ^ 16'h0001;
        sendFlag();
        foreach (payload[i]) sendStuffed(payload[i]);
        sendStuffed(fcs[7:0]);
        sendStuffed(fcs[15:8]);
        sendClose();
    endtask

    task automatic expData(input int v);
        expQ.push_back('{KDATA, v, 0});
    endtask

    task automatic readBytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            RdBuff = 1'b1;
            readChk = 1'b1;
        end
        @(negedge Clk);
        RdBuff = 1'b0;
        readChk = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check(name, expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_DataOut", DataOut, 0);
        check("rst_Ready", Ready, 0);
        check("rst_FrameSize", FrameSize, 0);
        check("rst_Overflow", Overflow, 0);
        check("rst_Abort", AbortSignal, 0);
        check("rst_FrameError", FrameError, 0);
        check("rst_FCSerr", FCSerr, 0);
        Rst = 1'b0;

        payload = {8'hA5, 8'h3C};
        expQ.push_back('{KREADY, 2, 0});
        sendFrame(1'b0);
        check("ready_latency", readyCyc - closeCyc, 1);
        expData(8'hA5);
        expData(8'h3C);
        readBytes(2);
        check("ready_clear_on_last_read", Ready, 0);
        @(negedge Clk);
        RdBuff = 1'b1;
        @(negedge Clk);
        RdBuff = 1'b0;
        check("idle_read_holds", DataOut, 8'h3C);
        drain("valid_frame_drain");

        payload = {8'hFF};
        expQ.push_back('{KREADY, 1, 0});
        sendFrame(1'b0);
        expData(8'hFF);
        readBytes(1);
        drain("destuff_drain");

        expQ.push_back('{KABORT, 0, 0});
        sendFlag();
        sendStuffed(8'hA5);
        for (int i = 0; i < 8; i++) sendBit(1'b1);
        pause();
        check("abort_no_ready", Ready, 0);
        payload = {8'h5A, 8'hC3};
        expQ.push_back('{KREADY, 2, 0});
        sendFrame(1'b0);
        expData(8'h5A);
        expData(8'hC3);
        readBytes(2);
        drain("abort_drain");

        payload = {8'h12, 8'h34};
        expQ.push_back('{KFCS, 0, 0});
        sendFrame(1'b1);
        check("fcs_err_no_ready", Ready, 0);
        drain("fcs_drain");

        expQ.push_back('{KFERR, 0, 0});
        sendFlag();
        sendStuffed(8'hA5);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendClose();
        expQ.push_back('{KFERR, 0, 0});
        sendFlag();
        sendStuffed(8'h55);
        sendStuffed(8'h66);
        sendClose();
        check("short_no_ready", Ready, 0);
        drain("frame_error_drain");

        sendRaw(8'h7E);
        sendRaw(8'h7E);
        sendRaw(8'h7E);
        pause();
        drain("triple_flag_drain");

        payload = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        expQ.push_back('{KREADY, 2, 1});
        sendFrame(1'b0);
        expData(8'h01);
        readBytes(1);
        @(negedge Clk);
        RdBuff = 1'b1;
        Drop = 1'b1;
        @(negedge Clk);
        RdBuff = 1'b0;
        Drop = 1'b0;
        check("drop_clears_ready", Ready, 0);
        check("drop_wins_dataout", DataOut, 8'h01);
        drain("overflow_drain");

        payload = {8'h11, 8'h22};
        expQ.push_back('{KREADY, 2, 0});
        sendFrame(1'b0);
        payload = {8'h33, 8'h44};
        sendFrame(1'b0);
        expData(8'h11);
        expData(8'h22);
        readBytes(2);
        drain("hold_drain");

        payload = {8'h77, 8'h88};
        fcs = ~crcOfPayload();
        sendFlag();
        sendStuffed(8'h77);
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("midrst_DataOut", DataOut, 0);
        check("midrst_Ready", Ready, 0);
        check("midrst_FrameSize", FrameSize, 0);
        check("midrst_Overflow", Overflow, 0);
        @(negedge Clk);
        Rst = 1'b0;
        sendStuffed(8'h88);
        sendStuffed(fcs[7:0]);
        sendStuffed(fcs[15:8]);
        sendClose();
        check("midrst_no_ready", Ready, 0);
        payload = {8'h99};
        expQ.push_back('{KREADY, 1, 0});
        sendFrame(1'b0);
        expData(8'h99);
        readBytes(1);
        drain("post_reset_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/hdlc_rx_deframer.md
# hdlc_rx_deframer

Parametrised HDLC receive deframer for the HDLC controller's Rx path. It takes the serial line bit stream and performs flag hunting, zero-bit removal and abort detection. It assembles LSB-first bytes into a frame buffer of `BUF_DEPTH` bytes and optionally checks the CRC-16-CCITT FCS. It then holds one completed frame for byte-wise readout by the register interface. It supersedes the fixed 128-byte, always-FCS receive channel.

## Interface
- `BUF_DEPTH`, 128: frame buffer capacity in bytes, including the FCS bytes; at least 4.
- `FCS_EN`, 1: when 1, check the FCS and exclude its 2 bytes from `FrameSize`; when 0, skip the check and count all bytes.
- `SZ_W`, `$clog2(BUF_DEPTH+1)`: width of `FrameSize`; derived, do not override.
- `Clk` in 1: single clock; all logic is on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `RxEN` in 1: bit enable; `Rx` is sampled only when this is high.
- `Rx` in 1: serial line bit.
- `RdBuff` in 1: pop one byte from the held frame.
- `Drop` in 1: discard the held frame.
- `DataOut` out 8: read data, registered.
- `Ready` out 1: a frame is held and readable.
- `FrameSize` out SZ_W: readable byte count of the held frame; valid while `Ready`=1.
- `Overflow` out 1: the held frame exceeded `BUF_DEPTH`; valid while `Ready`=1.
- `AbortSignal` out 1: 1-cycle pulse when an abort is detected.
- `FrameError` out 1: 1-cycle pulse for a non-aligned or too-short frame.
- `FCSerr` out 1: 1-cycle pulse when the FCS check fails.

## Operation
- **Window and ones counters**
  - On each sampled bit (`RxEN`=1), `Rx` shifts into an 8-bit window.
  - The bit shifted out, 8 samples old, is the data-path bit.
  - Flag: the window equals 8'h7E.
  - Abort: 7 consecutive sampled 1s.
  - An outgoing-ones counter drives destuffing: an outgoing 0 that follows five outgoing 1s is discarded, and the counter clears.
- **States: HUNT, RECV, HOLD**
  - HUNT: the data path is ignored. On a flag, clear the bit count, byte count and CRC (0xFFFF), then go to RECV.
  - RECV: each kept outgoing bit enters the byte register LSB-first and updates the CRC (reflected polynomial 0x8408). Every 8th kept bit writes the byte to `buf[bytecnt]` and increments `bytecnt`.
  - RECV, `bytecnt`=`BUF_DEPTH`: further bytes are discarded and an internal overflow flag is set.
- **Closing flag in RECV**
  - `bytecnt`=0 with no pending bits: shared or back-to-back flag; stay in RECV with state cleared.
  - Pending bits (count mod 8 ≠ 0), or `bytecnt` < 3 when `FCS_EN`=1, or `bytecnt` < 1 when `FCS_EN`=0: pulse `FrameError` and go to RECV with state cleared, since the flag also opens the next frame.
  - `FCS_EN`=1 and CRC ≠ 16'hF0B8 residue: pulse `FCSerr`; same next state.
  - Otherwise go to HOLD with `Ready`=1 and `FrameSize` = `bytecnt` − 2·`FCS_EN`.
  - On overflow, the size is computed from `BUF_DEPTH` and `Overflow`=1; the FCS is not checked.
- **Abort**
  - In RECV: pulse `AbortSignal`, discard the frame and go to HUNT.
  - In HUNT or HOLD: ignored.
- **HOLD**
  - Line input is ignored; frames arriving while HOLD is active are lost.
  - `RdBuff` loads `buf[rdptr]` into `DataOut` and increments `rdptr`.
  - The edge that reads byte `FrameSize`−1 also clears `Ready` and goes to HUNT.
  - `Drop` clears `Ready` and goes to HUNT immediately.
  - If `Drop` and `RdBuff` occur in the same cycle, `Drop` wins and `DataOut` is unchanged.
  - `RdBuff` while `Ready`=0 is ignored and `DataOut` holds.
  - `FrameSize`=0 (only possible when `FCS_EN`=1 and the frame is 2 bytes): not reachable, because 3 bytes is the minimum.
- **Reset values**: state HUNT, window 8'h00, all counters 0, CRC 0xFFFF, `DataOut`=8'h00, and `Ready`, `FrameSize`, `Overflow`, `AbortSignal`, `FrameError`, `FCSerr` all 0. Buffer contents are not reset.

## Timing
- `RxEN`=0 freezes the window, counters, CRC and FSM; reads remain functional.
- Edge N samples the last flag bit, so the window shows 8'h7E after N. The close decision is taken at edge N+1, and `Ready` or an error pulse is high after N+1.
- `AbortSignal` is high for one cycle after the edge following the 7th 1 sample.
- `DataOut` is valid the cycle after the `RdBuff` edge; back-to-back reads are allowed, one byte per cycle.
- `Rst` mid-frame or mid-read returns to reset values asynchronously; the partial frame is lost.

## Test plan
- **Valid frame**: flag, bytes 0xA5, 0x3C, FCS from the bench model, flag, `FCS_EN`=1 → `Ready`=1 two edges after the last flag bit, `FrameSize`=2; reads return 0xA5 then 0x3C, and `Ready`=0 after the second read.
- **Destuffing**: payload 0xFF sent as line bits 1,1,1,1,1,0,1,1,1 → read-back 0xFF, `FrameSize`=1.
- **Abort**: flag, 0xA5, then 7 ones → `AbortSignal` pulses once, `Ready` stays 0, and the next valid frame is received normally.
- **Errors**:
  - Corrupted FCS byte → `FCSerr` pulse with `Ready`=0.
  - Closing flag after 12 bits → `FrameError` pulse.
  - 0x7E,0x7E,0x7E → no pulses.
- **Overflow**: `BUF_DEPTH`=4, 6-byte frame plus FCS → `Ready`=1, `Overflow`=1, `FrameSize`=2; `Drop` → `Ready`=0 next cycle.
- **Reset and hold**: `Rst` pulsed mid-frame → all outputs 0 and no `Ready` on that frame's closing flag. Second frame sent while HOLD is active → ignored, and the first frame reads out intact.
